// File: rtl/parity_s_register_gen.sv
// S register, odd/even parity generate and check with sticky alarm and saturating
// alarm count, G = +-0 detect, and the CYR/SR/CYL/EDOP editing-pulse sequencer.
//
// state  | meaning
// IDLE   | no editing pulse; waiting for T02 with S on an editing address
// ACTIVE | one-hot EDIT held until T12A closes the memory cycle
module parity_s_register_gen #(
   parameter int S_WIDTH    = 12,
   parameter int G_WIDTH    = 16,
   parameter int PAR_BIT    = 14,
   parameter int ODD_PARITY = 1,
   parameter int EDIT_BASE  = 'o20,
   parameter int ALM_CNT_W  = 8
) (
   input  logic                 SIM_CLK,
   input  logic                 SIM_RST,
   input  logic                 GOJAM,
   input  logic                 CSG,
   input  logic                 WSG,
   input  logic [S_WIDTH-1:0]   WL,
   output logic [S_WIDTH-1:0]   S,
   input  logic [G_WIDTH-1:0]   G,
   input  logic                 TPARG,
   output logic                 GPAR,
   input  logic                 CHKPAR,
   input  logic                 CHK_INH,
   output logic                 PALE,
   output logic [ALM_CNT_W-1:0] ALM_CNT,
   output logic                 GEQZRO,
   input  logic                 T02,
   input  logic                 T12A,
   output logic [3:0]           EDIT
);

   localparam int                 DW        = G_WIDTH - 1;
   localparam logic               PAR_SENSE = (ODD_PARITY != 0);
   localparam logic [S_WIDTH-1:0] EDIT_LO   = S_WIDTH'(EDIT_BASE);
   localparam logic [S_WIDTH-1:0] EDIT_HI   = S_WIDTH'(EDIT_BASE + 3);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state_q, state_d;
   logic [S_WIDTH-1:0]     s_q, s_d;
   logic                   gpar_q, gpar_d;
   logic                   pale_q, pale_d;
   logic [ALM_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   geqz_q, geqz_d;
   logic [3:0]             edit_q, edit_d;

   logic [DW-1:0]          data;
   logic                   chk_fail;
   logic                   addr_hit;
   logic [S_WIDTH-1:0]     s_off;

   // Data word is G with the parity bit squeezed out.
   always_comb begin
      data = '0;
      for (int i = 0; i < G_WIDTH; i++) begin
         if (i < PAR_BIT)
            data[i] = G[i];
         else if (i > PAR_BIT)
            data[i-1] = G[i];
      end
   end

   assign chk_fail = CHKPAR & ~CHK_INH & ((^G) != PAR_SENSE);
   assign addr_hit = (s_q >= EDIT_LO) && (s_q <= EDIT_HI);
   assign s_off    = s_q - EDIT_LO;

   always_comb begin
      s_d = s_q;
      if (WSG)
         s_d = WL;
      else if (CSG)
         s_d = '0;

      gpar_d = TPARG ? ((^data) ^ PAR_SENSE) : gpar_q;
      geqz_d = (data == '0) || (data == '1);

      // A failure in the same cycle as GOJAM must still leave the latch set.
      pale_d = pale_q;
      cnt_d  = cnt_q;
      if (chk_fail) begin
         pale_d = 1'b1;
         if (cnt_q != '1)
            cnt_d = cnt_q + ALM_CNT_W'(1);
      end else if (GOJAM) begin
         pale_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      edit_d  = edit_q;
      if (GOJAM) begin
         state_d = IDLE;
         edit_d  = 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (T02 && addr_hit) begin
                  state_d = ACTIVE;
                  edit_d  = 4'b0001 << s_off[1:0];
               end
            end
            ACTIVE: begin
               if (T12A) begin
                  state_d = IDLE;
                  edit_d  = 4'b0000;
               end
            end
            default: begin
               state_d = IDLE;
               edit_d  = 4'b0000;
            end
         endcase
      end
   end

   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         state_q <= IDLE;
         s_q     <= '0;
         gpar_q  <= 1'b0;
         pale_q  <= 1'b0;
         cnt_q   <= '0;
         geqz_q  <= 1'b0;
         edit_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         gpar_q  <= gpar_d;
         pale_q  <= pale_d;
         cnt_q   <= cnt_d;
         geqz_q  <= geqz_d;
         edit_q  <= edit_d;
      end
   end

   assign S       = s_q;
   assign GPAR    = gpar_q;
   assign PALE    = pale_q;
   assign ALM_CNT = cnt_q;
   assign GEQZRO  = geqz_q;
   assign EDIT    = edit_q;

endmodule
